// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and limits for the two-master arbiter.
package ahb_pkg;

    // HTRANS encodings
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    // HSIZE encodings
    localparam logic [2:0] BYTE = 3'b000;
    localparam logic [2:0] HALF = 3'b001;
    localparam logic [2:0] WORD = 3'b010;

    // Hold counter limits: HOLD_MAX must fit the 4-bit owner counter
    localparam int HOLD_MAX_MIN   = 1;
    localparam int HOLD_MAX_LIMIT = 15;
    localparam int CNT_W          = 4;

    // NONSEQ and SEQ both carry HTRANS[1] = 1; IDLE and BUSY do not
    function automatic logic is_active(input logic [1:0] htrans);
        return htrans[1];
    endfunction

endpackage

// File: rtl/ahb_arb_input_stage.sv
// One-entry input stage for one master. A transfer presented while this
// master is not being granted is parked in the hold register and the
// master is stalled (via its HREADY) until the arbiter issues it.
module ahb_arb_input_stage
    import ahb_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [AW-1:0] haddr_i,
    input  logic [1:0]    htrans_i,
    input  logic          hwrite_i,
    input  logic [2:0]    hsize_i,
    input  logic          hready_i,    // this master's HREADY as driven by the arbiter
    input  logic          sel_i,       // arbiter grants this master this cycle
    input  logic          s_hready_i,  // bus-side ready
    output logic          req_o,
    output logic          pend_o,
    output logic [AW-1:0] addr_o,
    output logic [1:0]    trans_o,
    output logic          write_o,
    output logic [2:0]    size_o
);

    logic          pend_q, pend_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0]    trans_q, trans_d;
    logic          write_q, write_d;
    logic [2:0]    size_q, size_d;
    logic          live;
    logic          capture;
    logic          clear;

    // Request detection and capture/clear decisions. Capture needs a live
    // transfer (HREADY = 1 to the master) while clear needs pend_q, which
    // forces that HREADY low unless this master owns the data phase; in
    // that case the transfer is live only with s_hready_i = 1, and capture
    // then requires !sel_i, so the two never coincide.
    always_comb begin
        live    = is_active(htrans_i) & hready_i;
        capture = live & ~(sel_i & s_hready_i);
        clear   = sel_i & s_hready_i & pend_q;
        pend_d  = pend_q;
        addr_d  = addr_q;
        trans_d = trans_q;
        write_d = write_q;
        size_d  = size_q;
        if (capture) begin
            pend_d  = 1'b1;
            addr_d  = haddr_i;
            trans_d = htrans_i;
            write_d = hwrite_i;
            size_d  = hsize_i;
        end else if (clear) begin
            pend_d = 1'b0;
        end
    end

    // Hold register and pend flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q  <= 1'b0;
            addr_q  <= '0;
            trans_q <= IDLE;
            write_q <= 1'b0;
            size_q  <= BYTE;
        end else begin
            pend_q  <= pend_d;
            addr_q  <= addr_d;
            trans_q <= trans_d;
            write_q <= write_d;
            size_q  <= size_d;
        end
    end

    // Issued attributes: buffered copy takes precedence over live inputs
    always_comb begin
        req_o   = pend_q | live;
        pend_o  = pend_q;
        addr_o  = pend_q ? addr_q  : haddr_i;
        trans_o = pend_q ? trans_q : htrans_i;
        write_o = pend_q ? write_q : hwrite_i;
        size_o  = pend_q ? size_q  : hsize_i;
    end

endmodule

// File: rtl/ahb_lite_master_arbiter.sv
// Two-master AHB-Lite arbiter in front of a single bus-system port.
// The current owner keeps the bus while it requests, but once it has had
// HOLD_MAX accepted transfers with the other master waiting, the other
// master wins the next address-phase boundary. Grant never moves while a
// data phase is being stretched by the slave.
//
// Handshake: a master transfer is accepted at a rising HCLK edge where it
// drives NONSEQ/SEQ and sees its own Mx_HREADY = 1; a bus transfer is
// accepted at an edge where S_HTRANS is non-IDLE and S_HREADY = 1.
module ahb_lite_master_arbiter
    import ahb_pkg::*;
#(
    parameter int HOLD_MAX = 4,
    parameter int AW       = 32,
    parameter int DW       = 32
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic [AW-1:0] M0_HADDR,
    input  logic [1:0]    M0_HTRANS,
    input  logic          M0_HWRITE,
    input  logic [2:0]    M0_HSIZE,
    input  logic [DW-1:0] M0_HWDATA,
    output logic          M0_HREADY,
    output logic [DW-1:0] M0_HRDATA,
    input  logic [AW-1:0] M1_HADDR,
    input  logic [1:0]    M1_HTRANS,
    input  logic          M1_HWRITE,
    input  logic [2:0]    M1_HSIZE,
    input  logic [DW-1:0] M1_HWDATA,
    output logic          M1_HREADY,
    output logic [DW-1:0] M1_HRDATA,
    output logic [AW-1:0] S_HADDR,
    output logic [1:0]    S_HTRANS,
    output logic          S_HWRITE,
    output logic [2:0]    S_HSIZE,
    output logic [DW-1:0] S_HWDATA,
    input  logic          S_HREADY,
    input  logic [DW-1:0] S_HRDATA,
    output logic          GNT
);

    // Out-of-range HOLD_MAX values are clamped into the counter's range
    localparam int HOLD_EFF = (HOLD_MAX > HOLD_MAX_LIMIT) ? HOLD_MAX_LIMIT :
                              (HOLD_MAX < HOLD_MAX_MIN)   ? HOLD_MAX_MIN   : HOLD_MAX;
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_EFF);

    logic             req0, req1, pend0, pend1;
    logic [AW-1:0]    addr0, addr1;
    logic [1:0]       trans0, trans1;
    logic             write0, write1;
    logic [2:0]       size0, size1;

    logic             own_q, own_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gnt_q;
    logic             dvalid_q, dvalid_d;
    logic             downer_q, downer_d;
    logic             gnt, req_gnt, req_own, req_oth;
    logic [1:0]       trans_g;

    ahb_arb_input_stage #(.AW(AW)) u_stage0 (
        .clk_i(HCLK), .rst_i(HRESET),
        .haddr_i(M0_HADDR), .htrans_i(M0_HTRANS), .hwrite_i(M0_HWRITE), .hsize_i(M0_HSIZE),
        .hready_i(M0_HREADY), .sel_i(~gnt), .s_hready_i(S_HREADY),
        .req_o(req0), .pend_o(pend0),
        .addr_o(addr0), .trans_o(trans0), .write_o(write0), .size_o(size0)
    );

    ahb_arb_input_stage #(.AW(AW)) u_stage1 (
        .clk_i(HCLK), .rst_i(HRESET),
        .haddr_i(M1_HADDR), .htrans_i(M1_HTRANS), .hwrite_i(M1_HWRITE), .hsize_i(M1_HSIZE),
        .hready_i(M1_HREADY), .sel_i(gnt), .s_hready_i(S_HREADY),
        .req_o(req1), .pend_o(pend1),
        .addr_o(addr1), .trans_o(trans1), .write_o(write1), .size_o(size1)
    );

    // Grant selection: frozen while an issued data phase is stretched,
    // otherwise owner priority bounded by the hold counter.
    always_comb begin
        req_own = own_q ? req1 : req0;
        req_oth = own_q ? req0 : req1;
        if (!S_HREADY && dvalid_q) begin
            gnt = gnt_q;
        end else if (req_own && !(req_oth && cnt_q == HOLD_LIM)) begin
            gnt = own_q;
        end else if (req_oth) begin
            gnt = ~own_q;
        end else begin
            gnt = own_q;
        end
        req_gnt = gnt ? req1 : req0;
    end

    // Next owner, hold count and data-phase tracking at accepted boundaries
    always_comb begin
        own_d    = own_q;
        cnt_d    = cnt_q;
        dvalid_d = dvalid_q;
        downer_d = downer_q;
        if (S_HREADY) begin
            dvalid_d = req_gnt;
            downer_d = gnt;
            if (req_gnt) begin
                if (gnt == own_q) begin
                    cnt_d = (cnt_q == HOLD_LIM) ? cnt_q : cnt_q + CNT_W'(1);
                end else begin
                    own_d = gnt;
                    cnt_d = CNT_W'(1);
                end
            end
        end
    end

    // Arbiter state registers; reset drops any in-flight data phase
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            own_q    <= 1'b0;
            cnt_q    <= '0;
            gnt_q    <= 1'b0;
            dvalid_q <= 1'b0;
            downer_q <= 1'b0;
        end else begin
            own_q    <= own_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt;
            dvalid_q <= dvalid_d;
            downer_q <= downer_d;
        end
    end

    // Slave-side address phase; a SEQ that starts a new ownership run is
    // not a continuation from the slave's point of view, so it becomes NONSEQ
    always_comb begin
        trans_g  = gnt ? trans1 : trans0;
        S_HADDR  = gnt ? addr1  : addr0;
        S_HWRITE = gnt ? write1 : write0;
        S_HSIZE  = gnt ? size1  : size0;
        S_HTRANS = IDLE;
        if (req_gnt) begin
            case (trans_g)
                BUSY:    S_HTRANS = IDLE;
                SEQ:     S_HTRANS = (gnt != own_q) ? NONSEQ : SEQ;
                default: S_HTRANS = trans_g;
            endcase
        end
    end

    // Data phase routing and per-master ready
    always_comb begin
        S_HWDATA  = downer_q ? M1_HWDATA : M0_HWDATA;
        M0_HRDATA = S_HRDATA;
        M1_HRDATA = S_HRDATA;
        M0_HREADY = (dvalid_q && !downer_q) ? S_HREADY : ~pend0;
        M1_HREADY = (dvalid_q &&  downer_q) ? S_HREADY : ~pend1;
        GNT       = gnt;
    end

endmodule

// File: tb/tb_ahb_lite_master_arbiter.sv
// Directed bench for the two-master AHB-Lite arbiter. Inputs change 1ns
// after each rising edge; outputs are sampled on the falling edge.
module tb_ahb_lite_master_arbiter;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;
    localparam logic [2:0] S_WORD   = 3'b010;

    logic        HCLK;
    logic        HRESET;
    logic [31:0] M0_HADDR, M1_HADDR;
    logic [1:0]  M0_HTRANS, M1_HTRANS;
    logic        M0_HWRITE, M1_HWRITE;
    logic [2:0]  M0_HSIZE, M1_HSIZE;
    logic [31:0] M0_HWDATA, M1_HWDATA;
    logic        M0_HREADY, M1_HREADY;
    logic [31:0] M0_HRDATA, M1_HRDATA;
    logic [31:0] S_HADDR;
    logic [1:0]  S_HTRANS;
    logic        S_HWRITE;
    logic [2:0]  S_HSIZE;
    logic [31:0] S_HWDATA;
    logic        S_HREADY;
    logic [31:0] S_HRDATA;
    logic        GNT;

    int checks = 0;
    int errors = 0;

    ahb_lite_master_arbiter #(.HOLD_MAX(4), .AW(32), .DW(32)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE),
        .M0_HSIZE(M0_HSIZE), .M0_HWDATA(M0_HWDATA), .M0_HREADY(M0_HREADY), .M0_HRDATA(M0_HRDATA),
        .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE),
        .M1_HSIZE(M1_HSIZE), .M1_HWDATA(M1_HWDATA), .M1_HREADY(M1_HREADY), .M1_HRDATA(M1_HRDATA),
        .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE), .S_HSIZE(S_HSIZE),
        .S_HWDATA(S_HWDATA), .S_HREADY(S_HREADY), .S_HRDATA(S_HRDATA), .GNT(GNT)
    );

    // Clock
    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic sample();
        @(negedge HCLK);
    endtask

    task automatic m0_drive(input logic [31:0] a, input logic [1:0] t, input logic w);
        M0_HADDR = a; M0_HTRANS = t; M0_HWRITE = w; M0_HSIZE = S_WORD;
    endtask

    task automatic m1_drive(input logic [31:0] a, input logic [1:0] t, input logic w);
        M1_HADDR = a; M1_HTRANS = t; M1_HWRITE = w; M1_HSIZE = S_WORD;
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        S_HREADY = 1'b1;
        m0_drive(32'h0, T_IDLE, 1'b0);
        m1_drive(32'h0, T_IDLE, 1'b0);
        tick();
        tick();
        HRESET = 1'b0;
    endtask

    initial begin
        M0_HWDATA = '0; M1_HWDATA = '0; S_HRDATA = '0;
        do_reset();

        // Reset state with both masters idle
        sample();
        check("rst_htrans", S_HTRANS, T_IDLE);
        check("rst_m0_hready", M0_HREADY, 1);
        check("rst_m1_hready", M1_HREADY, 1);
        check("rst_gnt", GNT, 0);
        tick();

        // Test 1: M0 pass-through reads at 0x0/0x4/0x8
        m0_drive(32'h0, T_NONSEQ, 1'b0);
        sample();
        check("t1_c0_haddr", S_HADDR, 32'h0);
        check("t1_c0_htrans", S_HTRANS, T_NONSEQ);
        check("t1_c0_hsize", S_HSIZE, S_WORD);
        check("t1_c0_gnt", GNT, 0);
        check("t1_c0_m1_hready", M1_HREADY, 1);
        tick();
        m0_drive(32'h4, T_NONSEQ, 1'b0); S_HRDATA = 32'h0000_00A0;
        sample();
        check("t1_c1_haddr", S_HADDR, 32'h4);
        check("t1_c1_m0_hready", M0_HREADY, 1);
        check("t1_c1_m0_hrdata", M0_HRDATA, 32'h0000_00A0);
        check("t1_c1_m1_hready", M1_HREADY, 1);
        tick();
        m0_drive(32'h8, T_NONSEQ, 1'b0); S_HRDATA = 32'h0000_00A4;
        sample();
        check("t1_c2_haddr", S_HADDR, 32'h8);
        check("t1_c2_m0_hrdata", M0_HRDATA, 32'h0000_00A4);
        check("t1_c2_gnt", GNT, 0);
        tick();
        m0_drive(32'h8, T_IDLE, 1'b0); S_HRDATA = 32'h0000_00A8;
        sample();
        check("t1_c3_m0_hrdata", M0_HRDATA, 32'h0000_00A8);
        check("t1_c3_htrans", S_HTRANS, T_IDLE);
        check("t1_c3_m1_hready", M1_HREADY, 1);
        tick();

        // Test 2: simultaneous requests after reset
        do_reset();
        m0_drive(32'h100, T_NONSEQ, 1'b0);
        m1_drive(32'h200, T_NONSEQ, 1'b0);
        sample();
        check("t2_c0_haddr", S_HADDR, 32'h100);
        check("t2_c0_gnt", GNT, 0);
        check("t2_c0_m1_hready", M1_HREADY, 1);
        tick();
        m0_drive(32'h100, T_IDLE, 1'b0);
        m1_drive(32'h200, T_IDLE, 1'b0);
        sample();
        check("t2_c1_m1_hready", M1_HREADY, 0);
        check("t2_c1_haddr", S_HADDR, 32'h200);
        check("t2_c1_htrans", S_HTRANS, T_NONSEQ);
        check("t2_c1_gnt", GNT, 1);
        check("t2_c1_m0_hready", M0_HREADY, 1);
        tick();
        sample();
        check("t2_c2_m1_hready", M1_HREADY, 1);
        check("t2_c2_htrans", S_HTRANS, T_IDLE);
        check("t2_c2_gnt_parked", GNT, 1);
        tick();

        // Test 3: bounded hold, M0 streams while M1 waits
        do_reset();
        m0_drive(32'h300, T_NONSEQ, 1'b0);
        m1_drive(32'h400, T_NONSEQ, 1'b0);
        sample();
        check("t3_c0_haddr", S_HADDR, 32'h300);
        check("t3_c0_gnt", GNT, 0);
        tick();
        m0_drive(32'h304, T_SEQ, 1'b0);
        m1_drive(32'h400, T_IDLE, 1'b0);
        sample();
        check("t3_c1_haddr", S_HADDR, 32'h304);
        check("t3_c1_htrans", S_HTRANS, T_SEQ);
        check("t3_c1_m1_hready", M1_HREADY, 0);
        tick();
        m0_drive(32'h308, T_SEQ, 1'b0);
        sample();
        check("t3_c2_haddr", S_HADDR, 32'h308);
        check("t3_c2_gnt", GNT, 0);
        tick();
        m0_drive(32'h30C, T_SEQ, 1'b0);
        sample();
        check("t3_c3_haddr", S_HADDR, 32'h30C);
        check("t3_c3_gnt", GNT, 0);
        tick();
        m0_drive(32'h310, T_SEQ, 1'b0);
        sample();
        check("t3_c4_gnt", GNT, 1);
        check("t3_c4_haddr", S_HADDR, 32'h400);
        check("t3_c4_htrans", S_HTRANS, T_NONSEQ);
        check("t3_c4_m0_hready", M0_HREADY, 1);
        tick();
        m0_drive(32'h314, T_SEQ, 1'b0);
        sample();
        check("t3_c5_gnt", GNT, 0);
        check("t3_c5_haddr", S_HADDR, 32'h310);
        check("t3_c5_htrans", S_HTRANS, T_NONSEQ);
        check("t3_c5_m0_hready", M0_HREADY, 0);
        check("t3_c5_m1_hready", M1_HREADY, 1);
        tick();
        sample();
        check("t3_c6_haddr", S_HADDR, 32'h314);
        check("t3_c6_htrans", S_HTRANS, T_SEQ);
        check("t3_c6_m0_hready", M0_HREADY, 1);
        tick();
        m0_drive(32'h314, T_IDLE, 1'b0);

        // Test 4: wait states freeze the grant
        do_reset();
        m0_drive(32'h500, T_NONSEQ, 1'b0);
        sample();
        check("t4_c0_haddr", S_HADDR, 32'h500);
        tick();
        m0_drive(32'h500, T_IDLE, 1'b0);
        m1_drive(32'h600, T_NONSEQ, 1'b0);
        S_HREADY = 1'b0;
        sample();
        check("t4_c1_gnt", GNT, 0);
        check("t4_c1_htrans", S_HTRANS, T_IDLE);
        check("t4_c1_haddr", S_HADDR, 32'h500);
        check("t4_c1_m0_hready", M0_HREADY, 0);
        check("t4_c1_m1_hready", M1_HREADY, 1);
        tick();
        m1_drive(32'h600, T_IDLE, 1'b0);
        sample();
        check("t4_c2_gnt", GNT, 0);
        check("t4_c2_htrans", S_HTRANS, T_IDLE);
        check("t4_c2_haddr", S_HADDR, 32'h500);
        check("t4_c2_m0_hready", M0_HREADY, 0);
        check("t4_c2_m1_hready", M1_HREADY, 0);
        tick();
        S_HREADY = 1'b1;
        sample();
        check("t4_c3_m0_hready", M0_HREADY, 1);
        check("t4_c3_gnt", GNT, 1);
        check("t4_c3_haddr", S_HADDR, 32'h600);
        check("t4_c3_htrans", S_HTRANS, T_NONSEQ);
        check("t4_c3_m1_hready", M1_HREADY, 0);
        tick();
        sample();
        check("t4_c4_m1_hready", M1_HREADY, 1);
        tick();

        // Test 5: buffered M1 write
        do_reset();
        m0_drive(32'h100, T_NONSEQ, 1'b0);
        M0_HWDATA = 32'h1111_1111;
        m1_drive(32'h2000_0010, T_NONSEQ, 1'b1);
        sample();
        check("t5_c0_gnt", GNT, 0);
        check("t5_c0_m1_hready", M1_HREADY, 1);
        tick();
        m0_drive(32'h100, T_IDLE, 1'b0);
        m1_drive(32'h2000_0010, T_IDLE, 1'b0);
        M1_HWDATA = 32'hDEAD_BEEF;
        sample();
        check("t5_c1_gnt", GNT, 1);
        check("t5_c1_haddr", S_HADDR, 32'h2000_0010);
        check("t5_c1_hwrite", S_HWRITE, 1);
        check("t5_c1_htrans", S_HTRANS, T_NONSEQ);
        check("t5_c1_hwdata_m0", S_HWDATA, 32'h1111_1111);
        check("t5_c1_m1_hready", M1_HREADY, 0);
        tick();
        S_HREADY = 1'b0;
        sample();
        check("t5_c2_hwdata", S_HWDATA, 32'hDEAD_BEEF);
        check("t5_c2_m1_hready", M1_HREADY, 0);
        tick();
        S_HREADY = 1'b1;
        sample();
        check("t5_c3_hwdata", S_HWDATA, 32'hDEAD_BEEF);
        check("t5_c3_m1_hready", M1_HREADY, 1);
        tick();

        // Test 6: reset with a buffered M1 transfer and M0 data phase open
        do_reset();
        m0_drive(32'h700, T_NONSEQ, 1'b0);
        m1_drive(32'h800, T_NONSEQ, 1'b1);
        sample();
        check("t6_c0_gnt", GNT, 0);
        tick();
        m0_drive(32'h700, T_IDLE, 1'b0);
        m1_drive(32'h800, T_IDLE, 1'b0);
        S_HREADY = 1'b0;
        HRESET = 1'b1;
        sample();
        check("t6_c1_gnt_held", GNT, 0);
        check("t6_c1_m1_hready", M1_HREADY, 0);
        tick();
        HRESET = 1'b0;
        S_HREADY = 1'b1;
        sample();
        check("t6_c2_htrans", S_HTRANS, T_IDLE);
        check("t6_c2_m0_hready", M0_HREADY, 1);
        check("t6_c2_m1_hready", M1_HREADY, 1);
        check("t6_c2_gnt", GNT, 0);
        tick();
        sample();
        check("t6_c3_htrans", S_HTRANS, T_IDLE);
        check("t6_c3_gnt", GNT, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_lite_master_arbiter.md
Name: ahb_lite_master_arbiter

Overview:
- Two-master AHB-Lite arbiter that shares the single system bus port of AHBlite_sys_0 between the NfiVe32 CPU (M0) and a second master such as a DMA engine (M1).
- Sits between the masters and the bus system.
- Each master gets a one-entry input stage, so it never observes a grant handshake.
- Arbitration is priority-to-current-owner with a bounded hold (HOLD_MAX) to prevent starvation.

Parameters:
- HOLD_MAX, 4, consecutive accepted transfers the owner may issue while the other master requests; range 1..15.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- HCLK  input  1  bus clock.
- HRESET  input  1  synchronous, active-high reset.
- M0_HADDR / M1_HADDR  input  AW each  master address.
- M0_HTRANS / M1_HTRANS  input  2 each  master transfer type.
- M0_HWRITE / M1_HWRITE  input  1 each  master write strobe.
- M0_HSIZE / M1_HSIZE  input  3 each  master transfer size.
- M0_HWDATA / M1_HWDATA  input  DW each  master write data.
- M0_HREADY / M1_HREADY  output  1 each  per-master ready.
- M0_HRDATA / M1_HRDATA  output  DW each  read data, both copies of S_HRDATA.
- S_HADDR, S_HTRANS, S_HWRITE, S_HSIZE, S_HWDATA  output  AW/2/1/3/DW  to bus system.
- S_HREADY  input  1  bus system ready.
- S_HRDATA  input  DW  bus system read data.
- GNT  output  1  current address-phase owner (0 = M0, 1 = M1).

Behaviour:
Request detection:
- live_x = Mx_HTRANS[1] & Mx_HREADY.
- req_x = pend_x | live_x.
- Issued attributes come from the hold register when pend_x = 1, otherwise from the live inputs.

Grant selection:
- If S_HREADY = 0 and the previous cycle drove a non-IDLE transfer, gnt = gnt_q, so the slave address stays stable.
- Otherwise:
  - gnt = own if req_own and not (req_other and cnt == HOLD_MAX);
  - else gnt = other if req_other;
  - else gnt = own (parked).

Owner and count update, on every S_HREADY = 1 edge with req_gnt:
- If gnt == own: cnt = min(cnt + 1, HOLD_MAX).
- Else: own = gnt, cnt = 1.

Slave-side drive:
- S_HADDR, S_HWRITE, S_HSIZE are muxed from gnt.
- S_HTRANS = IDLE if !req_gnt.
- On the first transfer after an ownership change, SEQ is rewritten to NONSEQ.
- BUSY is forwarded as IDLE.

Data phase:
- dvalid and downer are registered on S_HREADY = 1 from (req_gnt, gnt).
- S_HWDATA = downer's HWDATA.
- Mx_HREADY = S_HREADY if (dvalid & downer == x); else 0 if pend_x; else 1.

Input stage (capture):
- Capture occurs when live_x and not (gnt == x & S_HREADY).
- On capture: hold register <= {HADDR, HTRANS, HWRITE, HSIZE}, pend_x = 1.
- pend_x clears when gnt == x & S_HREADY & pend_x.
- Capture and clear cannot occur in the same cycle for the same master.

Latency:
- Owner with an idle other master: zero added cycles (pure pass-through).
- Captured transfer: issued no earlier than the cycle after capture.

Simultaneous events:
- Both masters live at a boundary: own wins; the other is captured.
- Other master requests while cnt == HOLD_MAX: switch at the next S_HREADY = 1 boundary.
- No switch occurs during slave wait states.

Reset (synchronous, takes effect on the HCLK edge with HRESET = 1; also applies mid-transfer):
- pend_0 = pend_1 = 0, dvalid = 0, own = 0, gnt_q = 0, cnt = 0.
- Outputs after reset: S_HTRANS = IDLE, M0_HREADY = M1_HREADY = 1, GNT = 0.
- In-flight and buffered transfers are discarded; masters must also be reset.

No HRESP: the bus system has no error response.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS constants: IDLE 2'b00, BUSY 2'b01, NONSEQ 2'b10, SEQ 2'b11.
  - HSIZE constants: BYTE 3'b000, HALF 3'b001, WORD 3'b010.
  - HOLD_MAX range limit.
- Sub-module ahb_arb_input_stage contains the hold register, pend flag and req/attribute mux. It is instantiated once per master.

Test Plan:
1. M0 issues 3 NONSEQ word reads at 0x0000_0000/4/8 with S_HREADY = 1 and M1 idle → S_HADDR matches in the same cycles, M0_HRDATA follows one cycle later, M1_HREADY = 1 throughout, GNT = 0.
2. After reset, M0 and M1 both present NONSEQ in the same cycle; M0 then goes IDLE → M0 address on S in cycle 0; M1 captured (M1_HREADY = 1 in cycle 0, 0 in cycle 1); M1 address on S in cycle 1, GNT = 1; M1_HREADY = 1 in cycle 2.
3. HOLD_MAX = 4, M0 streams SEQ continuously while M1 requests → exactly 4 M0 transfers accepted, then one M1 transfer; M0's next transfer appears on S as NONSEQ.
4. S_HREADY held low 2 cycles during M0's data phase while M1 raises a request → S_HADDR/S_HTRANS stable, GNT unchanged, M0_HREADY = 0 for 2 cycles, M1 captured.
5. M1 buffered write of 0xDEADBEEF to 0x2000_0010 → S_HWDATA = 0xDEADBEEF in M1's data phase, M1_HREADY rises only when S_HREADY = 1.
6. HRESET = 1 asserted with pend_1 = 1 and a live M0 data phase → next cycle S_HTRANS = IDLE, both HREADY = 1, GNT = 0, M1 transfer never issued.
